// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, FSM encoding and event record for the PS/2 key decoder
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2
  } ps2_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
    logic [7:0] ascii;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_scan2ascii.sv
// rtl/ps2_scan2ascii.sv - combinational PS/2 set-2 scancode to ASCII lookup
module ps2_scan2ascii (
  input  logic [7:0] code,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'h00;
    case (code)
      8'h1C: ascii = "a";
      8'h32: ascii = "b";
      8'h21: ascii = "c";
      8'h23: ascii = "d";
      8'h24: ascii = "e";
      8'h2B: ascii = "f";
      8'h34: ascii = "g";
      8'h33: ascii = "h";
      8'h43: ascii = "i";
      8'h3B: ascii = "j";
      8'h42: ascii = "k";
      8'h4B: ascii = "l";
      8'h3A: ascii = "m";
      8'h31: ascii = "n";
      8'h44: ascii = "o";
      8'h4D: ascii = "p";
      8'h15: ascii = "q";
      8'h2D: ascii = "r";
      8'h1B: ascii = "s";
      8'h2C: ascii = "t";
      8'h3C: ascii = "u";
      8'h2A: ascii = "v";
      8'h1D: ascii = "w";
      8'h22: ascii = "x";
      8'h35: ascii = "y";
      8'h1A: ascii = "z";
      8'h45: ascii = "0";
      8'h16: ascii = "1";
      8'h1E: ascii = "2";
      8'h26: ascii = "3";
      8'h25: ascii = "4";
      8'h2E: ascii = "5";
      8'h36: ascii = "6";
      8'h3D: ascii = "7";
      8'h3E: ascii = "8";
      8'h46: ascii = "9";
      8'h29: ascii = 8'h20;
      8'h5A: ascii = 8'h0D;
      default: ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - pops PS/2 receiver FIFO, strips E0/F0 prefixes, emits key events
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  input  logic             kbd_overflow,
  output logic             kbd_nextdata_n,
  output logic             evt_valid,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             evt_repeat,
  output logic [7:0]       evt_ascii,
  output logic             key_down,
  output logic [7:0]       held_code,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err
);

  ps2_state_e state;
  ps2_evt_t   evt_q;
  logic [7:0] byte_q;
  logic       ext_f;
  logic       brk_f;
  logic       held_ext;

  logic [7:0] ascii_lk;
  logic       eff_ext;
  logic       eff_brk;
  logic       held_match;

  ps2_scan2ascii u_scan2ascii (
    .code  (byte_q),
    .ascii (ascii_lk)
  );

  // An overflow in the same cycle invalidates any prefix already seen.
  assign eff_ext    = ext_f & ~kbd_overflow;
  assign eff_brk    = brk_f & ~kbd_overflow;
  assign held_match = key_down && (held_ext == eff_ext) && (held_code == byte_q);

  assign evt_code   = evt_q.code;
  assign evt_ext    = evt_q.ext;
  assign evt_break  = evt_q.brk;
  assign evt_repeat = evt_q.rep;
  assign evt_ascii  = evt_q.ascii;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state          <= FETCH;
      kbd_nextdata_n <= 1'b1;
      byte_q         <= 8'h00;
      ext_f          <= 1'b0;
      brk_f          <= 1'b0;
      evt_valid      <= 1'b0;
      evt_q          <= '0;
      key_down       <= 1'b0;
      held_code      <= 8'h00;
      held_ext       <= 1'b0;
      press_cnt      <= '0;
      err            <= 1'b0;
    end else begin
      evt_valid      <= 1'b0;
      kbd_nextdata_n <= 1'b1;
      if (kbd_overflow) err <= 1'b1;

      case (state)
        FETCH: begin
          if (kbd_ready) begin
            byte_q         <= kbd_data;
            kbd_nextdata_n <= 1'b0;
            state          <= POP;
          end
        end
        POP: begin
          state <= SETTLE;
          if (byte_q == PS2_EXT) begin
            ext_f <= 1'b1;
          end else if (byte_q == PS2_BRK) begin
            brk_f <= 1'b1;
          end else begin
            evt_valid   <= 1'b1;
            evt_q.code  <= byte_q;
            evt_q.ext   <= eff_ext;
            evt_q.brk   <= eff_brk;
            evt_q.rep   <= ~eff_brk & held_match;
            evt_q.ascii <= eff_ext ? 8'h00 : ascii_lk;
            ext_f       <= 1'b0;
            brk_f       <= 1'b0;
            if (eff_brk) begin
              if (held_match) key_down <= 1'b0;
            end else if (!held_match) begin
              key_down  <= 1'b1;
              held_code <= byte_q;
              held_ext  <= eff_ext;
              press_cnt <= press_cnt + CNT_W'(1);
            end
          end
        end
        SETTLE: state <= FETCH;
        default: state <= FETCH;
      endcase

      // Placed last so it overrides a prefix set in the same POP cycle.
      if (kbd_overflow) begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
    logic [7:0] ascii;
    logic       kd;
    logic [7:0] held;
    logic [7:0] cnt;
  } ev_t;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] kbd_data = 8'h00;
  logic       kbd_ready = 1'b0;
  logic       kbd_overflow = 1'b0;
  logic       kbd_nextdata_n;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       evt_repeat;
  logic [7:0] evt_ascii;
  logic       key_down;
  logic [7:0] held_code;
  logic [7:0] press_cnt;
  logic       err;

  int errors = 0;
  int checks = 0;
  logic [7:0] fifo_q[$];
  ev_t        evq[$];
  int         pops = 0;
  int         low_run = 0;
  logic       bad_pop = 1'b0;

  ps2_key_decoder #(.CNT_W(8)) dut (
    .clk            (clk),
    .clrn           (clrn),
    .kbd_data       (kbd_data),
    .kbd_ready      (kbd_ready),
    .kbd_overflow   (kbd_overflow),
    .kbd_nextdata_n (kbd_nextdata_n),
    .evt_valid      (evt_valid),
    .evt_code       (evt_code),
    .evt_ext        (evt_ext),
    .evt_break      (evt_break),
    .evt_repeat     (evt_repeat),
    .evt_ascii      (evt_ascii),
    .key_down       (key_down),
    .held_code      (held_code),
    .press_cnt      (press_cnt),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Receiver FIFO model plus event and pop-strobe monitor, all on the falling edge.
  always @(negedge clk) begin
    if (clrn && !kbd_nextdata_n) begin
      pops++;
      low_run++;
      if (low_run > 1) bad_pop = 1'b1;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end else begin
      low_run = 0;
    end
    kbd_ready = (fifo_q.size() > 0);
    kbd_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    if (evt_valid)
      evq.push_back('{evt_code, evt_ext, evt_break, evt_repeat, evt_ascii, key_down, held_code, press_cnt});
  end

  task automatic pulse_reset();
    clrn = 1'b0;
    fifo_q.delete();
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    evq.delete();
    pops = 0;
    bad_pop = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (fifo_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fifo_q.size() !== 0) begin
      errors++;
      $display("FAIL wait_idle: %0d bytes left, required 0", fifo_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_pop(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (kbd_nextdata_n && n < budget);
    checks++;
    if (kbd_nextdata_n !== 1'b0) begin
      errors++;
      $display("FAIL wait_pop: no pop strobe within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    checks += 6;
    if (kbd_nextdata_n !== 1'b1) begin errors++; $display("FAIL rst_nextdata_n: got %b want 1", kbd_nextdata_n); end
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst_evt_valid: got %b want 0", evt_valid); end
    if (evt_code !== 8'h00) begin errors++; $display("FAIL rst_evt_code: got %h want 00", evt_code); end
    if (key_down !== 1'b0) begin errors++; $display("FAIL rst_key_down: got %b want 0", key_down); end
    if (press_cnt !== 8'h00) begin errors++; $display("FAIL rst_press_cnt: got %h want 00", press_cnt); end
    if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    pulse_reset();
  endtask

  task automatic test_press_release();
    pulse_reset();
    fifo_q = '{8'h1C, 8'hF0, 8'h1C};
    wait_idle(100);
    checks += 3;
    if (evq.size() !== 2) begin errors++; $display("FAIL pr_evt_count: got %0d want 2", evq.size()); end
    if (pops !== 3) begin errors++; $display("FAIL pr_pop_count: got %0d want 3", pops); end
    if (bad_pop !== 1'b0) begin errors++; $display("FAIL pr_pop_width: strobe low >1 cycle"); end
    if (evq.size() == 2) begin
      checks += 8;
      if (evq[0].code !== 8'h1C) begin errors++; $display("FAIL pr_press_code: got %h want 1c", evq[0].code); end
      if (evq[0].ascii !== 8'h61) begin errors++; $display("FAIL pr_press_ascii: got %h want 61", evq[0].ascii); end
      if (evq[0].brk !== 1'b0) begin errors++; $display("FAIL pr_press_brk: got %b want 0", evq[0].brk); end
      if (evq[0].kd !== 1'b1) begin errors++; $display("FAIL pr_press_key_down: got %b want 1", evq[0].kd); end
      if (evq[0].cnt !== 8'h01) begin errors++; $display("FAIL pr_press_cnt: got %h want 01", evq[0].cnt); end
      if (evq[1].code !== 8'h1C) begin errors++; $display("FAIL pr_break_code: got %h want 1c", evq[1].code); end
      if (evq[1].brk !== 1'b1) begin errors++; $display("FAIL pr_break_brk: got %b want 1", evq[1].brk); end
      if (evq[1].kd !== 1'b0) begin errors++; $display("FAIL pr_break_key_down: got %b want 0", evq[1].kd); end
    end
  endtask

  task automatic test_repeat();
    logic exp_rep[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    pulse_reset();
    fifo_q = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    wait_idle(100);
    checks += 2;
    if (evq.size() !== 4) begin errors++; $display("FAIL rep_evt_count: got %0d want 4", evq.size()); end
    if (press_cnt !== 8'h01) begin errors++; $display("FAIL rep_press_cnt: got %h want 01", press_cnt); end
    for (int i = 0; i < 4 && i < evq.size(); i++) begin
      checks++;
      if (evq[i].rep !== exp_rep[i]) begin errors++; $display("FAIL rep_flag[%0d]: got %b want %b", i, evq[i].rep, exp_rep[i]); end
    end
  endtask

  task automatic test_extended();
    pulse_reset();
    fifo_q = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    wait_idle(100);
    checks += 2;
    if (evq.size() !== 2) begin errors++; $display("FAIL ext_evt_count: got %0d want 2", evq.size()); end
    if (key_down !== 1'b0) begin errors++; $display("FAIL ext_key_down: got %b want 0", key_down); end
    if (evq.size() == 2) begin
      checks += 6;
      if (evq[0].code !== 8'h75) begin errors++; $display("FAIL ext_press_code: got %h want 75", evq[0].code); end
      if (evq[0].ext !== 1'b1) begin errors++; $display("FAIL ext_press_ext: got %b want 1", evq[0].ext); end
      if (evq[0].ascii !== 8'h00) begin errors++; $display("FAIL ext_press_ascii: got %h want 00", evq[0].ascii); end
      if (evq[0].brk !== 1'b0) begin errors++; $display("FAIL ext_press_brk: got %b want 0", evq[0].brk); end
      if (evq[1].ext !== 1'b1) begin errors++; $display("FAIL ext_break_ext: got %b want 1", evq[1].ext); end
      if (evq[1].brk !== 1'b1) begin errors++; $display("FAIL ext_break_brk: got %b want 1", evq[1].brk); end
    end
  endtask

  task automatic test_rollover();
    pulse_reset();
    fifo_q = '{8'h1C, 8'h1B};
    wait_idle(100);
    checks += 2;
    if (held_code !== 8'h1B) begin errors++; $display("FAIL roll_held_code: got %h want 1b", held_code); end
    if (press_cnt !== 8'h02) begin errors++; $display("FAIL roll_press_cnt: got %h want 02", press_cnt); end
    evq.delete();
    fifo_q = '{8'hF0, 8'h1C};
    wait_idle(100);
    checks += 4;
    if (evq.size() !== 1) begin errors++; $display("FAIL roll_break_count: got %0d want 1", evq.size()); end
    else if (evq[0].brk !== 1'b1) begin errors++; $display("FAIL roll_break_brk: got %b want 1", evq[0].brk); end
    if (key_down !== 1'b1) begin errors++; $display("FAIL roll_key_down: got %b want 1", key_down); end
    if (held_code !== 8'h1B) begin errors++; $display("FAIL roll_held_after: got %h want 1b", held_code); end
    // Doubled break prefix still releases the held key.
    fifo_q = '{8'hF0, 8'hF0, 8'h1B};
    wait_idle(100);
    checks += 2;
    if (key_down !== 1'b0) begin errors++; $display("FAIL dbl_brk_key_down: got %b want 0", key_down); end
    if (held_code !== 8'h1B) begin errors++; $display("FAIL dbl_brk_held: got %h want 1b", held_code); end
  endtask

  task automatic test_mid_reset();
    pulse_reset();
    fifo_q = '{8'hF0};
    wait_pop(50);
    @(posedge clk);
    #2 clrn = 1'b0;
    #1;
    checks += 5;
    if (kbd_nextdata_n !== 1'b1) begin errors++; $display("FAIL mid_nextdata_n: got %b want 1", kbd_nextdata_n); end
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL mid_evt_valid: got %b want 0", evt_valid); end
    if (key_down !== 1'b0) begin errors++; $display("FAIL mid_key_down: got %b want 0", key_down); end
    if (press_cnt !== 8'h00) begin errors++; $display("FAIL mid_press_cnt: got %h want 00", press_cnt); end
    if (err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b want 0", err); end
    @(negedge clk);
    clrn = 1'b1;
    evq.delete();
    fifo_q = '{8'h1C};
    wait_idle(100);
    checks += 3;
    if (evq.size() !== 1) begin errors++; $display("FAIL mid_evt_count: got %0d want 1", evq.size()); end
    else if (evq[0].brk !== 1'b0) begin errors++; $display("FAIL mid_evt_brk: got %b want 0", evq[0].brk); end
    if (press_cnt !== 8'h01) begin errors++; $display("FAIL mid_press_cnt_after: got %h want 01", press_cnt); end
    if (key_down !== 1'b1) begin errors++; $display("FAIL mid_key_down_after: got %b want 1", key_down); end
  endtask

  task automatic test_wrap_overflow();
    pulse_reset();
    for (int i = 0; i < 255; i++) fifo_q.push_back((i % 2 == 0) ? 8'h1C : 8'h1B);
    wait_idle(2000);
    checks++;
    if (press_cnt !== 8'hFF) begin errors++; $display("FAIL wrap_cnt_255: got %h want ff", press_cnt); end
    fifo_q.push_back(8'h1B);
    wait_idle(100);
    checks += 2;
    if (press_cnt !== 8'h00) begin errors++; $display("FAIL wrap_cnt_0: got %h want 00", press_cnt); end
    if (held_code !== 8'h1B) begin errors++; $display("FAIL wrap_held: got %h want 1b", held_code); end
    fifo_q.push_back(8'hE0);
    wait_pop(50);
    @(negedge clk);
    kbd_overflow = 1'b1;
    @(negedge clk);
    kbd_overflow = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", err); end
    evq.delete();
    fifo_q.push_back(8'h75);
    wait_idle(100);
    checks += 3;
    if (evq.size() !== 1) begin errors++; $display("FAIL ovf_evt_count: got %0d want 1", evq.size()); end
    else begin
      if (evq[0].ext !== 1'b0) begin errors++; $display("FAIL ovf_evt_ext: got %b want 0", evq[0].ext); end
      if (evq[0].code !== 8'h75) begin errors++; $display("FAIL ovf_evt_code: got %h want 75", evq[0].code); end
    end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL ovf_err_sticky: got %b want 1", err); end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_repeat();
    test_extended();
    test_rollover();
    test_mid_reset();
    test_wrap_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
